// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the acquisition FIFO read controller.
// The optional peak tracker in fifo_reader is enabled by defining FIFO_READER_PEAK_EN.
package fifo_reader_pkg;

    localparam int DATA_W_DEF  = 14;
    localparam int RD_DATA_W   = 16;
    localparam int RD_ZERO_BIT = 15;
    localparam int RD_OR_BIT   = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_RLO,
        ST_RHI,
        ST_HOLD,
        ST_DONE
    } rd_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_LO,
        PH_HI
    } pulse_phase_e;

    function automatic logic [RD_DATA_W-1:0] pack_rd_data(input logic or_bit,
                                                          input logic [DATA_W_DEF-1:0] data);
        logic [RD_DATA_W-1:0] word;
        word                   = '0;
        word[RD_ZERO_BIT]      = 1'b0;
        word[RD_OR_BIT]        = or_bit;
        word[DATA_W_DEF-1:0]   = data;
        return word;
    endfunction

endpackage

// File: rtl/fifo_rclk_pulse.sv
// One FIFO read pulse per go: RCLK low then high for RCLK_HALF clk_sys cycles each, REN held
// low throughout, and a capture strobe on the last high cycle. go restarts, abort cancels.
module fifo_rclk_pulse
    import fifo_reader_pkg::*;
#(
    parameter int RCLK_HALF = 2
) (
    input  logic clk_sys,
    input  logic RESET_N,
    input  logic go_i,
    input  logic abort_i,
    output logic rclk_o,
    output logic ren_n_o,
    output logic rise_o,
    output logic capture_o,
    output logic idle_o
);

    localparam int            CW   = (RCLK_HALF > 1) ? $clog2(RCLK_HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(RCLK_HALF - 1);

    pulse_phase_e  phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rclk_q, ren_n_q;
    logic          last;

    assign last = (cnt_q == LAST);

    // NOTE: every variable gets a default before any branch; a path that leaves one unassigned infers a latch.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + CW'(1);
        if (go_i) begin
            phase_d = PH_LO;
            cnt_d   = '0;
        end else if (abort_i) begin
            phase_d = PH_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (phase_q)
                PH_LO: begin
                    if (last) begin
                        phase_d = PH_HI;
                        cnt_d   = '0;
                    end
                end
                PH_HI: begin
                    if (last) begin
                        phase_d = PH_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (!RESET_N) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            rclk_q  <= 1'b0;
            ren_n_q <= 1'b1;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rclk_q  <= (phase_d == PH_HI);
            ren_n_q <= (phase_d == PH_IDLE);
        end
    end

    assign rclk_o    = rclk_q;
    assign ren_n_o   = ren_n_q;
    assign rise_o    = (phase_q == PH_LO) && last;
    assign capture_o = (phase_q == PH_HI) && last;
    assign idle_o    = (phase_q == PH_IDLE);

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller for the external acquisition FIFO: drains one frame into a one-word
// holding register for the ARM. Define FIFO_READER_PEAK_EN to track the frame's peak sample.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RCLK_HALF = 2,
    parameter int CNT_W     = 32
) (
    input  logic                 clk_sys,
    input  logic                 RESET_N,
    input  logic                 start,
    input  logic [CNT_W-1:0]     length,
    input  logic                 rd_req,
    output logic [RD_DATA_W-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 underrun,
    output logic [DATA_W-1:0]    peak,
    input  logic [DATA_W-1:0]    fifo_data,
    input  logic                 fifo_or,
    input  logic                 fifo_ef_n,
    output logic                 fifo_rclk,
    output logic                 fifo_ren_n,
    output logic                 fifo_oe_n
);

    rd_state_e         state_q, state_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              rd_valid_q, rd_valid_d;
    logic              underrun_q, underrun_d;
    logic              hold_or_q, hold_or_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              go;
    logic              capture_en;
    logic              pulse_rise, pulse_capture, pulse_idle;

    fifo_rclk_pulse #(
        .RCLK_HALF (RCLK_HALF)
    ) u_rclk_pulse (
        .clk_sys   (clk_sys),
        .RESET_N   (RESET_N),
        .go_i      (go),
        .abort_i   (start),
        .rclk_o    (fifo_rclk),
        .ren_n_o   (fifo_ren_n),
        .rise_o    (pulse_rise),
        .capture_o (pulse_capture),
        .idle_o    (pulse_idle)
    );

    assign busy       = state_q inside {ST_FETCH, ST_RLO, ST_RHI, ST_HOLD};
    assign done       = (state_q == ST_DONE);
    assign fifo_oe_n  = !busy;
    assign rd_valid   = rd_valid_q;
    assign underrun   = underrun_q;
    assign rd_data    = pack_rd_data(hold_or_q, DATA_W_DEF'(hold_data_q));
    assign capture_en = !start && (state_q == ST_RHI) && pulse_capture;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        rd_valid_d  = rd_valid_q;
        underrun_d  = underrun_q;
        hold_or_d   = hold_or_q;
        hold_data_d = hold_data_q;
        go          = 1'b0;

        if (start) begin
            // The first FETCH decision is taken on the start edge itself, so RLO begins next cycle.
            remaining_d = length;
            rd_valid_d  = 1'b0;
            underrun_d  = 1'b0;
            if (length == '0) begin
                state_d = ST_DONE;
            end else if (!fifo_ef_n) begin
                state_d = ST_FETCH;
            end else begin
                go      = 1'b1;
                state_d = ST_RLO;
            end
        end else begin
            if (rd_req && busy && !rd_valid_q) begin
                underrun_d = 1'b1;
            end
            unique case (state_q)
                ST_FETCH: begin
                    if (remaining_q == '0) begin
                        state_d = ST_DONE;
                    end else if (fifo_ef_n && pulse_idle) begin
                        go      = 1'b1;
                        state_d = ST_RLO;
                    end
                end
                ST_RLO: begin
                    if (pulse_rise) begin
                        state_d = ST_RHI;
                    end
                end
                ST_RHI: begin
                    if (pulse_capture) begin
                        hold_or_d   = fifo_or;
                        hold_data_d = fifo_data;
                        rd_valid_d  = 1'b1;
                        if (remaining_q != '0) begin
                            remaining_d = remaining_q - CNT_W'(1);
                        end
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (rd_req) begin
                        rd_valid_d = 1'b0;
                        state_d    = ST_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            rd_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            hold_or_q   <= 1'b0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            rd_valid_q  <= rd_valid_d;
            underrun_q  <= underrun_d;
            hold_or_q   <= hold_or_d;
            hold_data_q <= hold_data_d;
        end
    end

`ifdef FIFO_READER_PEAK_EN
    logic [DATA_W-1:0] peak_q;

    always_ff @(posedge clk_sys) begin
        if (!RESET_N || start) begin
            peak_q <= '0;
        end else if (capture_en && (fifo_data > peak_q)) begin
            peak_q <= fifo_data;
        end
    end

    assign peak = peak_q;
`else
    logic unused_capture_en;
    assign unused_capture_en = capture_en;
    assign peak              = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a timing-rule model of the frame read sequence checked every cycle,
// plus directed scenarios with hand-computed latencies and data words.
module tb_fifo_reader;

    localparam int DATA_W = 14;
    localparam int RH     = 2;
    localparam int CNT_W  = 32;

    logic              clk_sys   = 1'b0;
    logic              RESET_N   = 1'b0;
    logic              start     = 1'b0;
    logic [CNT_W-1:0]  length    = '0;
    logic              rd_req    = 1'b0;
    logic              fifo_ef_n = 1'b1;
    logic [DATA_W-1:0] fifo_data = '0;
    logic              fifo_or   = 1'b0;
    logic [15:0]       rd_data;
    logic              rd_valid, busy, done, underrun;
    logic [DATA_W-1:0] peak;
    logic              fifo_rclk, fifo_ren_n, fifo_oe_n;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    fifo_reader #(
        .DATA_W    (DATA_W),
        .RCLK_HALF (RH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_sys    (clk_sys),
        .RESET_N    (RESET_N),
        .start      (start),
        .length     (length),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun),
        .peak       (peak),
        .fifo_data  (fifo_data),
        .fifo_or    (fifo_or),
        .fifo_ef_n  (fifo_ef_n),
        .fifo_rclk  (fifo_rclk),
        .fifo_ren_n (fifo_ren_n),
        .fifo_oe_n  (fifo_oe_n)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // External FIFO: words {or, data}; each RCLK rising edge presents the next word.
    logic [14:0] fifo_mem[$];
    int          frame_id   = 0;
    int          seen_id    = 0;
    int          rd_ptr     = 0;
    int          act_edges  = 0;

    always @(posedge fifo_rclk) begin
        if (seen_id != frame_id) begin
            seen_id = frame_id;
            rd_ptr  = 0;
        end
        if (rd_ptr < fifo_mem.size()) begin
            {fifo_or, fifo_data} = fifo_mem[rd_ptr];
        end
        rd_ptr++;
        act_edges++;
    end

    // Model: a word arrives 2*RH edges after its read is launched; the launch happens on the
    // start edge when the FIFO is non-empty, otherwise on the first edge that sees it non-empty.
    bit                m_busy, m_done, m_valid, m_underrun, m_wait;
    int                m_timer, m_remaining, m_idx, m_edges;
    logic [15:0]       m_rd_data;
    logic [DATA_W-1:0] m_peak;
    logic [14:0]       m_w;

    always @(posedge clk_sys) begin
        if (!RESET_N) begin
            m_busy = 0; m_done = 0; m_valid = 0; m_underrun = 0; m_wait = 0;
            m_timer = 0; m_remaining = 0; m_idx = 0;
            m_rd_data = '0; m_peak = '0;
        end else if (start) begin
            m_remaining = int'(length);
            m_idx = 0; m_underrun = 0; m_valid = 0; m_done = 0; m_peak = '0;
            m_timer = 0; m_wait = 0;
            if (length == '0) begin
                m_busy = 0; m_done = 1;
            end else begin
                m_busy = 1;
                if (fifo_ef_n) m_timer = 2 * RH;
                else           m_wait  = 1;
            end
        end else begin
            if (rd_req && m_busy && !m_valid) m_underrun = 1;
            if (m_timer > 0) begin
                m_timer--;
                if (m_timer == RH) m_edges++;
                if (m_timer == 0) begin
                    m_w = (m_idx < fifo_mem.size()) ? fifo_mem[m_idx] : 15'h0;
                    m_idx++;
                    m_rd_data = {1'b0, m_w};
                    m_valid = 1;
                    if (m_remaining > 0) m_remaining--;
`ifdef FIFO_READER_PEAK_EN
                    if (m_w[13:0] > m_peak) m_peak = m_w[13:0];
`endif
                end
            end else if (m_wait) begin
                if (m_remaining == 0) begin
                    m_wait = 0; m_busy = 0; m_done = 1;
                end else if (fifo_ef_n) begin
                    m_wait = 0; m_timer = 2 * RH;
                end
            end else if (m_valid && rd_req) begin
                m_valid = 0; m_wait = 1;
            end
        end
    end

    always @(negedge clk_sys) begin
        if (cmp_en) begin
            check("rd_valid",   rd_valid,   m_valid);
            check("rd_data",    rd_data,    m_rd_data);
            check("busy",       busy,       m_busy);
            check("done",       done,       m_done);
            check("underrun",   underrun,   m_underrun);
            check("peak",       peak,       m_peak);
            check("fifo_oe_n",  fifo_oe_n,  !m_busy);
            check("fifo_ren_n", fifo_ren_n, !(m_timer > 0));
            check("fifo_rclk",  fifo_rclk,  (m_timer >= 1) && (m_timer <= RH));
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Ticks until the DUT shows rd_valid; n is the number of edges taken. start is a one-cycle pulse.
    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            start = 1'b0;
            n++;
            if (rd_valid === 1'b1) break;
        end
        check("wait_valid", rd_valid, 1'b1);
    endtask

    task automatic launch(input int len);
        frame_id++;
        length = CNT_W'(len);
        start  = 1'b1;
    endtask

    task automatic read_word(input logic [15:0] exp, input string name);
        tick();
        tick();
        check(name, rd_data, exp);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    int          n, e0;
    logic [15:0] word;
    logic [DATA_W-1:0] peak_a, peak_d;

    initial begin
`ifdef FIFO_READER_PEAK_EN
        peak_a = 14'h3FFF;
        peak_d = 14'h0888;
`else
        peak_a = '0;
        peak_d = '0;
`endif
        m_edges = 0;
        tick();
        cmp_en = 1'b1;
        tick();
        RESET_N = 1'b1;

        // Idle after reset: no RCLK, everything at reset values.
        for (int i = 0; i < 100; i++) tick();
        check("idle_edges", act_edges, 0);
        check("idle_rd_data", rd_data, 16'h0000);
        check("idle_oe_n", fifo_oe_n, 1'b1);

        // Three-word frame read by the ARM two cycles after each rd_valid.
        fifo_mem = '{15'h0123, 15'h3FFF, 15'h0001};
        e0 = act_edges;
        launch(3);
        wait_valid(n);
        check("start_to_valid", n, 2 * RH + 1);
        read_word(16'h0123, "word_a0");
        wait_valid(n);
        check("req_to_valid", n, 2 * RH + 1);
        read_word(16'h3FFF, "word_a1");
        wait_valid(n);
        read_word(16'h0001, "word_a2");
        check("done_at_req_plus1", done, 1'b0);
        tick();
        check("done_at_req_plus2", done, 1'b1);
        check("edges_a", act_edges - e0, 3);
        check("peak_a", peak, peak_a);
        check("model_edges_a", m_edges, 3);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        check("req_in_done_ignored", underrun, 1'b0);
        check("rd_data_held", rd_data, 16'h0001);

        // FIFO empty after start, then an underrun while the next word is being fetched.
        fifo_mem  = '{15'h0AAA, 15'h1555};
        fifo_ef_n = 1'b0;
        e0 = act_edges;
        launch(2);
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("empty_no_edges", act_edges - e0, 0);
        check("empty_no_valid", rd_valid, 1'b0);
        fifo_ef_n = 1'b1;
        wait_valid(n);
        check("release_to_valid", n, 2 * RH + 1);
        read_word(16'h0AAA, "word_b0");
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("underrun_set", underrun, 1'b1);
        wait_valid(n);
        read_word(16'h1555, "word_b1");
        tick();
        check("done_b", done, 1'b1);
        check("underrun_sticky", underrun, 1'b1);
        check("edges_b", act_edges - e0, 2);

        // Restart on the capture cycle of word 2: start wins, the old word is never captured.
        fifo_mem = '{15'h0100, 15'h0200, 15'h0300};
        e0 = act_edges;
        launch(3);
        wait_valid(n);
        check("underrun_cleared", underrun, 1'b0);
        read_word(16'h0100, "word_c0");
        for (int i = 0; i < 50 && m_timer != 1; i++) tick();
        check("restart_window", fifo_rclk, 1'b1);
        fifo_mem = '{15'h0777, 15'h0888};
        launch(2);
        tick();
        start = 1'b0;
        check("restart_no_capture", rd_data, 16'h0100);
        check("restart_valid_low", rd_valid, 1'b0);
        wait_valid(n);
        check("restart_to_valid", n, 2 * RH);
        read_word(16'h0777, "word_d0");
        wait_valid(n);
        read_word(16'h0888, "word_d1");
        tick();
        check("done_d", done, 1'b1);
        check("edges_cd", act_edges - e0, 4);
        check("peak_d", peak, peak_d);

        // Zero-length frame completes immediately without touching the FIFO.
        e0 = act_edges;
        launch(0);
        tick();
        start = 1'b0;
        check("len0_done", done, 1'b1);
        check("len0_busy", busy, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("len0_edges", act_edges - e0, 0);

        // Out-of-range flag lands in rd_data[14].
        fifo_mem = '{15'h4005};
        launch(1);
        wait_valid(n);
        word = rd_data;
        check("or_bit", word[14], 1'b1);
        read_word(16'h4005, "word_or");
        tick();
        check("done_or", done, 1'b1);

        // Reset during RLO abandons the frame with no further RCLK edge.
        fifo_mem = '{15'h0011};
        launch(1);
        tick();
        start = 1'b0;
        e0 = act_edges;
        RESET_N = 1'b0;
        tick();
        check("reset_rclk", fifo_rclk, 1'b0);
        check("reset_busy", busy, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        RESET_N = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("reset_edges", act_edges - e0, 0);
        check("reset_rd_data", rd_data, 16'h0000);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side controller for the external 14-bit acquisition FIFO, the counterpart to the write-side FIFO control that fills it during sampling. It drains one frame of `length` words under ARM control. It generates FIFO_RCLK, REN and OE pulses from clk_sys and keeps a one-word prefetch holding register, so an ARM read of the data register returns immediately. It sits between the ARM bus register decode (rd_req, rd_data) and the FIFO read pins, and reports frame completion and underrun.

## Interface
Parameters:
- DATA_W, 14, FIFO data width.
- RCLK_HALF, 2, clk_sys cycles per RCLK half-period (≥1).
- CNT_W, 32, width of frame length counter.

Ports:
- clk_sys  in  1  system clock, 100 MHz.
- RESET_N  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; begins or restarts a frame.
- length  in  CNT_W  words in frame; sampled on start.
- rd_req  in  1  one-cycle pulse per ARM read of the data register.
- rd_data  out  16  {1'b0, or_bit, data[13:0]} of the held word.
- rd_valid  out  1  holding register contains an unread word.
- busy  out  1  frame in progress.
- done  out  1  frame fully consumed; level until next start.
- underrun  out  1  sticky: rd_req arrived while busy and rd_valid=0.
- peak  out  DATA_W  maximum captured data in current frame.
- fifo_data  in  DATA_W  FIFO Q bus.
- fifo_or  in  1  ADC out-of-range bit stored alongside data.
- fifo_ef_n  in  1  FIFO empty flag, 0 = empty.
- fifo_rclk  out  1  FIFO read clock.
- fifo_ren_n  out  1  FIFO read enable, active-low.
- fifo_oe_n  out  1  FIFO output enable, active-low; low while busy.

## Operation
- States: IDLE, FETCH, RLO, RHI, HOLD, DONE.
- IDLE: waits for start.
- start (any state): latch remaining=length, clear underrun/done/peak, rd_valid=0, busy=1, ren_n=1, rclk=0.
  - If length=0 → DONE.
  - Otherwise → FETCH.
- FETCH:
  - If remaining=0 → DONE.
  - Else if fifo_ef_n=0, stay (no RCLK, ren_n=1).
  - Else → RLO.
- RLO: ren_n=0, rclk=0 for RCLK_HALF cycles → RHI.
- RHI: ren_n=0, rclk=1 for RCLK_HALF cycles. At the last RHI cycle edge:
  - capture {fifo_or, fifo_data} into the holding register;
  - rd_valid=1, remaining−=1, ren_n=1, rclk=0;
  - → HOLD.
- HOLD: on rd_req, rd_valid=0 next cycle → FETCH. rd_data stays stable until the next capture.
- rd_req while busy and rd_valid=0: underrun=1, request dropped, rd_data unchanged.
- rd_req in IDLE/DONE: ignored, no flag.
- DONE: busy=0, done=1, oe_n=1; stays until start.
- Reset values: rclk 0, ren_n 1, oe_n 1, rd_valid 0, busy 0, done 0, underrun 0, rd_data 0, peak 0, state IDLE. Reset mid-frame abandons the frame immediately; no further RCLK edge is emitted.
- Counter arithmetic: remaining is unsigned CNT_W and never decrements below 0.

## Timing
- start at cycle 0 → FETCH at cycle 1 → RLO cycles 1..RCLK_HALF → RHI next RCLK_HALF cycles → rd_valid high at cycle 2·RCLK_HALF+1. With the default, this is cycle 5.
- rd_req at cycle n with FIFO non-empty → rd_valid low at n+1, high again at n+2·RCLK_HALF+2.
- One RCLK rising edge per word exactly. RCLK period is 2·RCLK_HALF clk_sys cycles.
- fifo_ef_n is evaluated only in FETCH, never during RLO/RHI.
- Last word: rd_req in HOLD with remaining=0 → FETCH → DONE; done rises 2 cycles after rd_req.
- start coinciding with rd_req: start wins.

## Configuration
- FIFO_READER_PEAK_EN defined:
  - peak updated at each capture to max(peak, data), unsigned compare;
  - updated in the same cycle rd_valid rises;
  - cleared on start.
- Undefined: peak tied to 0, no comparator logic.

## Structure
- fifo_reader_pkg holds:
  - the state enum;
  - DATA_W default;
  - the rd_data packing constants (bit 15 zero, bit 14 OR flag).
- One sub-module, fifo_rclk_pulse: given a go pulse and RCLK_HALF, emits one rclk/ren_n pulse and a one-cycle capture strobe; reports idle.

## Test plan
- Reset release, no start → all outputs at reset values; fifo_rclk static 0 for 100 cycles.
- length=3, FIFO holds 0x0123/0x3FFF/0x0001, rd_req 2 cycles after each rd_valid:
  - rd_data returns 0x0123, 0x3FFF, 0x0001 in order;
  - exactly 3 RCLK edges;
  - done=1 two cycles after third rd_req;
  - peak=0x3FFF with the macro, 0 without.
- FIFO empty (fifo_ef_n=0) for 20 cycles after start → no RCLK. Release → rd_valid at release+2·RCLK_HALF+1.
- rd_req while rd_valid=0 mid-frame → underrun=1 and sticky; word count unaffected; next start clears it.
- start during RHI of word 2 → no capture; remaining reloaded; the next RCLK edge begins the new frame.
- length=0 → done next cycle, busy never high, no RCLK; fifo_or=1 on a word sets rd_data[14].
